// File: rtl/word_unpacker_if.sv
// Packed-word input and sample output stream of the word unpacker.
interface word_unpacker_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned NUM_WORDS  = 16
);
    logic [DATA_WIDTH*NUM_WORDS-1:0] i_data;
    logic                            i_data_valid;
    logic                            o_ready;
    logic [DATA_WIDTH-1:0]           o_data;
    logic                            o_data_valid;
    logic                            o_last;
    logic                            i_ready;

    // Unpacker side.
    modport slave (
        input  i_data, i_data_valid, i_ready,
        output o_ready, o_data, o_data_valid, o_last
    );

    // Producer/consumer side driving the unpacker.
    modport master (
        output i_data, i_data_valid, i_ready,
        input  o_ready, o_data, o_data_valid, o_last
    );
endinterface

// File: rtl/word_unpacker.sv
// Wide-to-narrow serializer: takes one packed word of NUM_WORDS samples and
// emits them one per cycle, lane 0 first, on a valid/ready stream.
module word_unpacker #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned NUM_WORDS  = 16
) (
    input logic          clock,
    input logic          reset,
    word_unpacker_if.slave bus
);
    localparam int unsigned PW    = DATA_WIDTH * NUM_WORDS;
    localparam int unsigned IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    hold_q, hold_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             last_lane;
    logic [DATA_WIDTH-1:0] lane_data;

    assign last_lane = (idx_q == LAST_IDX);

    // Ready depends only on registered state and downstream ready.
    assign bus.o_ready      = (state_q == IDLE) || (last_lane && bus.i_ready);
    assign bus.o_data_valid = (state_q == SEND);
    assign bus.o_last       = (state_q == SEND) && last_lane;
    assign bus.o_data       = lane_data;

    // Select the currently indexed lane of the held word.
    always_comb begin
        lane_data = '0;
        for (int unsigned k = 0; k < NUM_WORDS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                lane_data = hold_q[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Next-state: load on input transfer, advance lane on output transfer.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (bus.i_data_valid) begin
                    hold_d  = bus.i_data;
                    idx_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (bus.i_ready) begin
                    if (!last_lane) begin
                        idx_d = idx_q + 1'b1;
                    end else if (bus.i_data_valid) begin
                        // Zero-bubble reload: last lane leaves as the next word enters.
                        hold_d = bus.i_data;
                        idx_d  = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, held word and lane counter registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            hold_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            idx_q   <= idx_d;
        end
    end
endmodule

// File: tb/tb_word_unpacker.sv
// Self-checking bench for word_unpacker (DATA_WIDTH=16, NUM_WORDS=16).
module tb_word_unpacker;
    localparam int DW = 16;
    localparam int NW = 16;
    localparam int PW = DW * NW;

    logic clock = 1'b0;
    logic reset = 1'b0;

    word_unpacker_if #(.DATA_WIDTH(DW), .NUM_WORDS(NW)) bus ();

    word_unpacker #(.DATA_WIDTH(DW), .NUM_WORDS(NW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic          dv;
        logic [PW-1:0] data;
        logic          rdy;
        logic          ev;
        logic [DW-1:0] ed;
        logic          el;
        logic          er;
        logic          cd;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [PW-1:0] mkword(input logic [DW-1:0] base);
        logic [PW-1:0] w;
        w = '0;
        for (int k = 0; k < NW; k++) w[k*DW +: DW] = base + DW'(k);
        return w;
    endfunction

    // Called at posedge+1: drive, check at negedge, advance to next posedge+1.
    task automatic step(input logic dv, input logic [PW-1:0] d, input logic rdy,
                        input logic ev, input logic [DW-1:0] ed, input logic el,
                        input logic er, input logic cd);
        bus.i_data_valid = dv;
        bus.i_data       = d;
        bus.i_ready      = rdy;
        @(negedge clock);
        chk("o_data_valid", 32'(bus.o_data_valid), 32'(ev));
        chk("o_ready", 32'(bus.o_ready), 32'(er));
        chk("o_last", 32'(bus.o_last), 32'(el));
        if (cd) chk("o_data", 32'(bus.o_data), 32'(ed));
        @(posedge clock);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        step(v.dv, v.data, v.rdy, v.ev, v.ed, v.el, v.er, v.cd);
    endtask

    vec_t tbl[NW+2];

    initial begin
        logic [PW-1:0] wa, wb;
        int lane, cyc;
        logic rdy;
        logic [3:0] pat;

        // Single word, lane k = k, i_ready held high.
        wa = mkword(16'h0000);
        tbl[0] = '{1'b1, wa, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1};
        for (int k = 0; k < NW; k++)
            tbl[k+1] = '{1'b0, '0, 1'b1, 1'b1, DW'(k), (k == NW-1), (k == NW-1), 1'b1};
        tbl[NW+1] = '{1'b0, '0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};

        bus.i_data = '0;
        bus.i_data_valid = 1'b0;
        bus.i_ready = 1'b0;

        // Reset values while reset is held low.
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_valid", 32'(bus.o_data_valid), 32'd0);
        chk("rst_last", 32'(bus.o_last), 32'd0);
        chk("rst_data", 32'(bus.o_data), 32'd0);
        chk("rst_ready", 32'(bus.o_ready), 32'd1);
        reset = 1'b1;
        @(posedge clock);
        #1;

        for (int i = 0; i < NW + 2; i++) run_vec(tbl[i]);

        // Two words back to back; second valid from first word's last-lane cycle.
        wa = mkword(16'h0100);
        wb = mkword(16'h0200);
        step(1'b1, wa, 1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < NW; k++)
            step(k == NW-1, (k == NW-1) ? wb : '0, 1'b1, 1'b1, 16'h0100 + DW'(k),
                 k == NW-1, k == NW-1, 1'b1);
        for (int k = 0; k < NW; k++)
            step(1'b0, '0, 1'b1, 1'b1, 16'h0200 + DW'(k), k == NW-1, k == NW-1, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0);

        // Stall pattern 1,0,0,1 with i_data scrambled while no word is offered.
        wa = mkword(16'h1111);
        pat = 4'b1001;
        step(1'b1, wa, 1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        lane = 0;
        cyc = 0;
        while (lane < NW && cyc < 100) begin
            rdy = pat[3 - (cyc % 4)];
            step(1'b0, {8{$urandom()}}, rdy, 1'b1, 16'h1111 + DW'(lane),
                 lane == NW-1, (lane == NW-1) && rdy, 1'b1);
            if (rdy) lane++;
            cyc++;
        end
        chk("stall_budget", 32'(lane), 32'(NW));
        step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0);

        // Next word offered while last lane is stalled: must wait.
        wa = mkword(16'h3000);
        wb = mkword(16'h4000);
        step(1'b1, wa, 1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < NW-1; k++)
            step(1'b0, '0, 1'b1, 1'b1, 16'h3000 + DW'(k), 1'b0, 1'b0, 1'b1);
        repeat (3) step(1'b1, wb, 1'b0, 1'b1, 16'h300F, 1'b1, 1'b0, 1'b1);
        step(1'b1, wb, 1'b1, 1'b1, 16'h300F, 1'b1, 1'b1, 1'b1);
        for (int k = 0; k < NW; k++)
            step(1'b0, '0, 1'b1, 1'b1, 16'h4000 + DW'(k), k == NW-1, k == NW-1, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset after lane 5 transfers.
        wa = mkword(16'h5000);
        step(1'b1, wa, 1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 6; k++)
            step(1'b0, '0, 1'b1, 1'b1, 16'h5000 + DW'(k), 1'b0, 1'b0, 1'b1);
        #2 reset = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.o_data_valid), 32'd0);
        chk("arst_data", 32'(bus.o_data), 32'd0);
        chk("arst_last", 32'(bus.o_last), 32'd0);
        chk("arst_ready", 32'(bus.o_ready), 32'd1);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        step(1'b0, '0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
        wa = mkword(16'h6000);
        step(1'b1, wa, 1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < NW; k++)
            step(1'b0, '0, 1'b1, 1'b1, 16'h6000 + DW'(k), k == NW-1, k == NW-1, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
